async_fifo_gray: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 22 ++
 rtl/sync_ff.sv | 22 ++
 rtl/async_fifo_gray.sv | 112 +++++++++++
 tb/tb_async_fifo_gray.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared Gray-code helpers and default watermark thresholds for the dual-clock FIFO.
package async_fifo_pkg;
   localparam int unsigned DefAlmostFullThresh  = 6;
   localparam int unsigned DefAlmostEmptyThresh = 2;
   localparam int unsigned MaxCodeWidth         = 32;

   // Narrower codes are zero-extended on entry; the low bits of the result are exact.
   function automatic logic [MaxCodeWidth-1:0] bin2gray(input logic [MaxCodeWidth-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MaxCodeWidth-1:0] gray2bin(input logic [MaxCodeWidth-1:0] g);
      logic [MaxCodeWidth-1:0] b;
      b = g;
      b = b ^ (b >> 1);
      b = b ^ (b >> 2);
      b = b ^ (b >> 4);
      b = b ^ (b >> 8);
      b = b ^ (b >> 16);
      return b;
   endfunction
endpackage

// File: rtl/sync_ff.sv
// Plain multi-stage flop chain with asynchronous clear, used for CDC and reset release.
module sync_ff #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [STAGES*WIDTH-1:0] chain_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[(STAGES-1)*WIDTH-1:0], d};
      end
   end

   assign q = chain_q[STAGES*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO: Gray pointers cross domains through sync_ff chains; flags and levels
// are registered from next-state pointers so they never lag on assertion.
module async_fifo_gray
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH          = 32,
   parameter int unsigned ADDR_WIDTH          = 3,
   parameter int unsigned SYNC_STAGES         = 2,
   parameter int unsigned ALMOST_FULL_THRESH  = DefAlmostFullThresh,
   parameter int unsigned ALMOST_EMPTY_THRESH = DefAlmostEmptyThresh
) (
   input  logic                  write_clock,
   input  logic                  read_clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  write_enable,
   output logic                  fifo_full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   write_level,
   output logic                  overflow,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  q_valid,
   output logic                  fifo_empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   read_level,
   output logic                  underflow
);
   localparam int unsigned PtrWidth = ADDR_WIDTH + 1;
   // Full when the Gray pointers differ only in their two top bits.
   localparam logic [PtrWidth-1:0] FullMask = {2'b11, {(ADDR_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   logic                w_run, r_run;
   logic [PtrWidth-1:0] wbin_q, wbin_d, wgray_q, wgray_d, rq_sync, wlevel_d;
   logic [PtrWidth-1:0] rbin_q, rbin_d, rgray_q, rgray_d, wq_sync, rlevel_d;
   logic                write_accept, full_d, read_accept, empty_d;

   sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_wrst_sync (
      .clock(write_clock), .reset(reset), .d(1'b1), .q(w_run)
   );
   sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rrst_sync (
      .clock(read_clock), .reset(reset), .d(1'b1), .q(r_run)
   );
   sync_ff #(.WIDTH(PtrWidth), .STAGES(SYNC_STAGES)) u_rptr_sync (
      .clock(write_clock), .reset(reset), .d(rgray_q), .q(rq_sync)
   );
   sync_ff #(.WIDTH(PtrWidth), .STAGES(SYNC_STAGES)) u_wptr_sync (
      .clock(read_clock), .reset(reset), .d(wgray_q), .q(wq_sync)
   );

   always_comb begin
      write_accept = w_run & write_enable & ~fifo_full;
      wbin_d       = wbin_q + PtrWidth'(write_accept);
      wgray_d      = PtrWidth'(bin2gray(MaxCodeWidth'(wbin_d)));
      full_d       = (wgray_d == (rq_sync ^ FullMask));
      wlevel_d     = wbin_d - PtrWidth'(gray2bin(MaxCodeWidth'(rq_sync)));
   end

   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         wbin_q      <= '0;
         wgray_q     <= '0;
         fifo_full   <= 1'b0;
         almost_full <= 1'b0;
         write_level <= '0;
         overflow    <= 1'b0;
      end else begin
         wbin_q      <= wbin_d;
         wgray_q     <= wgray_d;
         fifo_full   <= full_d;
         write_level <= wlevel_d;
         almost_full <= (wlevel_d >= PtrWidth'(ALMOST_FULL_THRESH));
         if (w_run && write_enable && fifo_full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge write_clock) begin
      if (write_accept) mem[wbin_q[ADDR_WIDTH-1:0]] <= data;
   end

   always_comb begin
      read_accept = r_run & read_enable & ~fifo_empty;
      rbin_d      = rbin_q + PtrWidth'(read_accept);
      rgray_d     = PtrWidth'(bin2gray(MaxCodeWidth'(rbin_d)));
      empty_d     = (rgray_d == wq_sync);
      rlevel_d    = PtrWidth'(gray2bin(MaxCodeWidth'(wq_sync))) - rbin_d;
   end

   always_ff @(posedge read_clock or posedge reset) begin
      if (reset) begin
         rbin_q       <= '0;
         rgray_q      <= '0;
         q            <= '0;
         q_valid      <= 1'b0;
         fifo_empty   <= 1'b1;
         almost_empty <= 1'b1;
         read_level   <= '0;
         underflow    <= 1'b0;
      end else begin
         rbin_q       <= rbin_d;
         rgray_q      <= rgray_d;
         q_valid      <= read_accept;
         fifo_empty   <= empty_d;
         read_level   <= rlevel_d;
         almost_empty <= (rlevel_d <= PtrWidth'(ALMOST_EMPTY_THRESH));
         if (read_accept) q <= mem[rbin_q[ADDR_WIDTH-1:0]];
         if (r_run && read_enable && fifo_empty) underflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_async_fifo_gray.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue model.
module tb_async_fifo_gray;
   localparam int unsigned DW     = 32;
   localparam int unsigned AW     = 3;
   localparam int          Depth  = 8;
   localparam int          WHalf  = 10;  // one time unit = 0.5 ns, write clock 100 MHz
   localparam int          NWords = 1000;

   logic          write_clock = 1'b0, read_clock = 1'b0, reset = 1'b0;
   logic [DW-1:0] data = '0;
   logic          write_enable = 1'b0, read_enable = 1'b0;
   logic          fifo_full, almost_full, overflow, q_valid, fifo_empty, almost_empty, underflow;
   logic [AW:0]   write_level, read_level;
   logic [DW-1:0] q;

   int            rhalf = 10;
   int            tests_run = 0, tests_failed = 0;
   logic [DW-1:0] model [$];
   int            wr_total = 0, rd_total = 0;

   async_fifo_gray dut (
      .write_clock(write_clock), .read_clock(read_clock), .reset(reset),
      .data(data), .write_enable(write_enable), .fifo_full(fifo_full),
      .almost_full(almost_full), .write_level(write_level), .overflow(overflow),
      .read_enable(read_enable), .q(q), .q_valid(q_valid), .fifo_empty(fifo_empty),
      .almost_empty(almost_empty), .read_level(read_level), .underflow(underflow)
   );

   initial forever #WHalf write_clock = ~write_clock;
   initial begin
      #2;
      forever #rhalf read_clock = ~read_clock;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_full"}, 64'(fifo_full), 64'(0));
      check({tag, "_afull"}, 64'(almost_full), 64'(0));
      check({tag, "_wlevel"}, 64'(write_level), 64'(0));
      check({tag, "_overflow"}, 64'(overflow), 64'(0));
      check({tag, "_q"}, 64'(q), 64'(0));
      check({tag, "_qvalid"}, 64'(q_valid), 64'(0));
      check({tag, "_empty"}, 64'(fifo_empty), 64'(1));
      check({tag, "_aempty"}, 64'(almost_empty), 64'(1));
      check({tag, "_rlevel"}, 64'(read_level), 64'(0));
      check({tag, "_underflow"}, 64'(underflow), 64'(0));
   endtask

   task automatic wr_cycle(input logic en, input logic [DW-1:0] d);
      @(negedge write_clock);
      write_enable = en;
      data = d;
      @(posedge write_clock);
      #4;
      write_enable = 1'b0;
   endtask

   task automatic rd_cycle(input logic en);
      @(negedge read_clock);
      read_enable = en;
      @(posedge read_clock);
      #4;
      read_enable = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge write_clock);
      #5 reset = 1'b1;
      #6 reset = 1'b0;
      repeat (4) @(posedge write_clock);
      repeat (4) @(posedge read_clock);
   endtask

   task automatic wait_not_empty(input string tag);
      int n;
      n = 0;
      while (fifo_empty && n < 10) begin
         @(posedge read_clock);
         #4;
         n++;
      end
      check(tag, 64'(fifo_empty), 64'(0));
   endtask

   initial begin
      int   n;
      logic saw_full;

      #1 reset = 1'b1;
      #2 check_reset_values("rst");
      #42 reset = 1'b0;
      repeat (4) @(posedge write_clock);

      // Fill, overflow, drain.
      for (int i = 0; i < 8; i++) begin
         wr_cycle(1'b1, DW'(i));
         check("t1_full", 64'(fifo_full), 64'(i == 7));
      end
      check("t1_wlevel", 64'(write_level), 64'(8));
      check("t1_afull", 64'(almost_full), 64'(1));
      wr_cycle(1'b1, 32'hFF);
      check("t1_overflow", 64'(overflow), 64'(1));
      check("t1_full_hold", 64'(fifo_full), 64'(1));
      repeat (5) @(posedge read_clock);
      #4;
      check("t1_rlevel", 64'(read_level), 64'(8));
      for (int i = 0; i < 8; i++) begin
         rd_cycle(1'b1);
         check("t1_q", 64'(q), 64'(i));
         check("t1_qvalid", 64'(q_valid), 64'(1));
         check("t1_empty", 64'(fifo_empty), 64'(i == 7));
      end
      rd_cycle(1'b0);
      check("t1_qvalid_drop", 64'(q_valid), 64'(0));
      check("t1_q_hold", 64'(q), 64'(7));
      check("t1_no_underflow", 64'(underflow), 64'(0));

      // Empty-release latency after a single write.
      repeat (6) @(posedge write_clock);
      #4;
      check("t2_full_release", 64'(fifo_full), 64'(0));
      check("t2_wlevel", 64'(write_level), 64'(0));
      @(negedge write_clock);
      write_enable = 1'b1;
      data = 32'hA5;
      @(posedge write_clock);
      #1 write_enable = 1'b0;
      n = 0;
      do begin
         @(posedge read_clock);
         n++;
         #1;
      end while (fifo_empty && n < 10);
      check("t2_empty_latency", 64'(n), 64'(3));
      rd_cycle(1'b1);
      check("t2_q", 64'(q), 64'(32'hA5));
      check("t2_qvalid", 64'(q_valid), 64'(1));
      rd_cycle(1'b0);
      check("t2_qvalid_pulse", 64'(q_valid), 64'(0));
      check("t2_q_hold", 64'(q), 64'(32'hA5));

      // Interleaved traffic across pointer wrap.
      saw_full = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wr_cycle(1'b1, DW'(i));
         saw_full |= fifo_full;
         wait_not_empty("t3_wait");
         rd_cycle(1'b1);
         check("t3_q", 64'(q), 64'(i));
      end
      check("t3_never_full", 64'(saw_full), 64'(0));

      // Underflow after reset is sticky.
      do_reset();
      rd_cycle(1'b1);
      check("t4_q", 64'(q), 64'(0));
      check("t4_qvalid", 64'(q_valid), 64'(0));
      check("t4_underflow", 64'(underflow), 64'(1));
      repeat (3) rd_cycle(1'b0);
      check("t4_underflow_sticky", 64'(underflow), 64'(1));

      // Mid-operation reset and release timing.
      for (int i = 0; i < 5; i++) wr_cycle(1'b1, DW'(32'h50 + i));
      repeat (6) @(posedge read_clock);
      #4;
      check("t5_rlevel_before", 64'(read_level), 64'(5));
      @(posedge write_clock);
      #6 reset = 1'b1;
      #1 check_reset_values("t5");
      #1 reset = 1'b0;
      wr_cycle(1'b1, 32'h11);
      check("t5_edge1_ignored", 64'(write_level), 64'(0));
      wr_cycle(1'b1, 32'h22);
      check("t5_edge2_ignored", 64'(write_level), 64'(0));
      wr_cycle(1'b1, 32'h33);
      check("t5_edge3_accepted", 64'(write_level), 64'(1));
      wait_not_empty("t5_wait");
      rd_cycle(1'b1);
      check("t5_q", 64'(q), 64'(32'h33));
      rd_cycle(1'b1);
      check("t5_only_one", 64'(q_valid), 64'(0));
      check("t5_underflow", 64'(underflow), 64'(1));

      // Randomized run, read clock about 37 MHz.
      rhalf = 27;
      do_reset();
      model.delete();
      wr_total = 0;
      rd_total = 0;
      fork
         begin : writer
            int   cyc;
            int   occ;
            logic we, full_s;
            cyc = 0;
            while (wr_total < NWords && cyc < 20000) begin
               @(negedge write_clock);
               occ = wr_total - rd_total;
               check("t6_afull", 64'(almost_full), 64'(int'(write_level) >= 6));
               check("t6_wlevel_ge_occ", 64'(int'(write_level) >= occ), 64'(1));
               check("t6_wlevel_max", 64'(int'(write_level) <= Depth), 64'(1));
               full_s = fifo_full;
               we = ($urandom_range(99) < ((wr_total < NWords / 2) ? 70 : 15));
               write_enable = we;
               data = $urandom;
               @(posedge write_clock);
               if (we && !full_s) begin
                  model.push_back(data);
                  wr_total++;
               end
               cyc++;
            end
            write_enable = 1'b0;
            check("t6_writer_done", 64'(wr_total), 64'(NWords));
         end
         begin : reader
            int            cyc;
            int            occ;
            logic          acc;
            logic [DW-1:0] exp_word;
            cyc = 0;
            while (rd_total < NWords && cyc < 12000) begin
               @(negedge read_clock);
               occ = wr_total - rd_total;
               check("t6_aempty", 64'(almost_empty), 64'(int'(read_level) <= 2));
               check("t6_rlevel_le_occ", 64'(int'(read_level) <= occ), 64'(1));
               check("t6_empty_sound", 64'(fifo_empty || occ > 0), 64'(1));
               read_enable = ($urandom_range(99) < 80);
               acc = read_enable && !fifo_empty;
               @(posedge read_clock);
               if (acc) rd_total++;
               #3;
               check("t6_qvalid", 64'(q_valid), 64'(acc));
               if (acc) begin
                  if (model.size() == 0) begin
                     check("t6_model_nonempty", 64'(0), 64'(1));
                  end else begin
                     exp_word = model.pop_front();
                     check("t6_q", 64'(q), 64'(exp_word));
                  end
               end
               cyc++;
            end
            read_enable = 1'b0;
            check("t6_reader_done", 64'(rd_total), 64'(NWords));
         end
      join
      check("t6_overflow", 64'(overflow), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
